// File: rtl/program_loader_if.sv
// program_loader_if: byte stream handshake between a source (master) and the loader (slave)
interface program_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  modport master (output rx_data, rx_valid, input rx_ready);
  modport slave (input rx_data, rx_valid, output rx_ready);
endinterface

// File: rtl/program_loader.sv
// program_loader: framed byte stream to little-endian 32-bit program memory writes
// Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte (CHK state).
module program_loader #(
  parameter int INSTR_ADDR_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  program_loader_if.slave             rx,
  output logic                        pgm,
  output logic                        mem_we,
  output logic [INSTR_ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]                 mem_wdata,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic [INSTR_ADDR_WIDTH:0]   word_count
);
  localparam int AW = INSTR_ADDR_WIDTH;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE, ERR} state_t;
  logic [7:0] csum;
`else
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, DONE, ERR} state_t;
`endif
  state_t      state;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [1:0]  idx;
  logic        xfer;
  logic [15:0] len_in;
  assign len_in = {rx.rx_data, len_lo};
  assign busy = !(state inside {IDLE, DONE, ERR});
  assign rx.rx_ready = busy;
  assign pgm = busy || state == ERR;
  assign xfer = rx.rx_valid && rx.rx_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      word_count <= '0;
      done <= 1'b0;
      error <= 1'b0;
      len_lo <= '0;
      len <= '0;
      idx <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      if (mem_we) begin
        mem_addr <= mem_addr + AW'(1);
        word_count <= word_count + (AW+1)'(1);
      end
      case (state)
        IDLE, DONE, ERR: if (start) begin
          state <= LEN_LO;
          done <= 1'b0;
          error <= 1'b0;
          word_count <= '0;
          idx <= '0;
          mem_addr <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum <= '0;
`endif
        end
        LEN_LO: if (xfer) begin
          len_lo <= rx.rx_data;
          state <= LEN_HI;
        end
        LEN_HI: if (xfer) begin
          len <= len_in;
          if (len_in == 16'd0) begin
            state <= DONE;
            done <= 1'b1;
          end else if (17'(len_in) > (17'd1 << AW)) begin
            state <= ERR;
            error <= 1'b1;
          end else
            state <= DATA;
        end
        DATA: if (xfer) begin
          mem_wdata[8*idx +: 8] <= rx.rx_data;
          idx <= idx + 2'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum <= csum ^ rx.rx_data;
`endif
          if (idx == 2'd3) begin
            mem_we <= 1'b1;
            if (17'(word_count) + 17'd1 == 17'(len)) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              state <= CHK;
`else
              state <= DONE;
              done <= 1'b1;
`endif
            end
          end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        CHK: if (xfer) begin
          state <= rx.rx_data == csum ? DONE : ERR;
          done <= rx.rx_data == csum;
          error <= rx.rx_data != csum;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule
